// File: rtl/des_decrypt_core_pkg.sv
// Shared DES constants: bit-permutation tables, S-boxes, decrypt key-rotation schedule.
// Table entries use DES numbering (1 = MSB), so a table entry T maps to vector bit WIDTH-T.
package des_decrypt_core_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 64;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                               8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                              24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                               2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // One 256-bit word per S-box: 4 rows of 16 nibbles, first entry in the top nibble.
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  // Parity bits (DES bits 8,16,..,64) never appear in PC1, so they drop out here.
  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  // Row is the outer bit pair {b5,b0}, column the inner four bits.
  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] x);
    logic [255:0] row;
    row = SBOX_T[n] << (4 * {x[5], x[0], x[4:1]});
    return row[255:252];
  endfunction

  // Right-rotate amount before decrypt round j; round 0 uses the PC1 halves unrotated (K16).
  function automatic logic [1:0] rsh_amt(input logic [3:0] j);
    if (j == 4'd0) return 2'd0;
    if (j == 4'd1 || j == 4'd8 || j == 4'd15) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Ciphertext-in / plaintext-out valid/ready bundle of the DES decrypt core.
interface des_decrypt_core_if;
  import des_decrypt_core_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] cipher_in;
  logic [KEY_W-1:0]   key;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] plain_out;
  logic               busy;

  modport slave (
    input  in_valid, cipher_in, key, out_ready,
    output in_ready, out_valid, plain_out, busy
  );

  modport master (
    output in_valid, cipher_in, key, out_ready,
    input  in_ready, out_valid, plain_out, busy
  );
endinterface

// File: rtl/des_decrypt_core_f.sv
// DES round function f(R,K): expansion, subkey mix, S-box substitution, P permutation.
module des_decrypt_core_f
  import des_decrypt_core_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] mix;
  logic [31:0] sub;

  assign mix = e_expand(r_i) ^ k_i;

  always_comb begin
    sub = '0;
    for (int i = 0; i < 8; i++) begin
      sub[31 - 4*i -: 4] = sbox(3'(i), mix[47 - 6*i -: 6]);
    end
  end

  assign f_o = p_perm(sub);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: ROUNDS_PER_CYCLE Feistel rounds per clock, subkeys K16..K1 derived
// on the fly by right-rotating the PC1 halves.
module des_decrypt_core
  import des_decrypt_core_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  des_decrypt_core_if.slave bus
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int RPC = ROUNDS_PER_CYCLE;

  state_e             state_q, state_d;
  logic [4:0]         rnd_q, rnd_d;
  logic [31:0]        l_q, l_d, r_q, r_d;
  logic [27:0]        c_q, c_d, d_q, d_d;
  logic [BLOCK_W-1:0] plain_q, plain_d;
  logic               last_c;

  logic [31:0] l_c [RPC+1];
  logic [31:0] r_c [RPC+1];
  logic [27:0] c_c [RPC+1];
  logic [27:0] d_c [RPC+1];

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;
  assign c_c[0] = c_q;
  assign d_c[0] = d_q;

  for (genvar g = 0; g < RPC; g++) begin : g_round
    logic [3:0]  j;
    logic [47:0] k;
    logic [31:0] f;

    assign j          = rnd_q[3:0] + 4'(g);
    assign c_c[g+1]   = rotr28(c_c[g], rsh_amt(j));
    assign d_c[g+1]   = rotr28(d_c[g], rsh_amt(j));
    assign k          = pc2_perm({c_c[g+1], d_c[g+1]});

    des_decrypt_core_f u_f (
      .r_i (r_c[g]),
      .k_i (k),
      .f_o (f)
    );

    assign l_c[g+1] = r_c[g];
    assign r_c[g+1] = l_c[g] ^ f;
  end

  assign last_c = (rnd_q + 5'(RPC)) == 5'd16;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    plain_d = plain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          {l_d, r_d} = ip_perm(bus.cipher_in);
          {c_d, d_d} = pc1_perm(bus.key);
          rnd_d      = '0;
          state_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        l_d   = l_c[RPC];
        r_d   = r_c[RPC];
        c_d   = c_c[RPC];
        d_d   = d_c[RPC];
        rnd_d = rnd_q + 5'(RPC);
        if (last_c) begin
          // Halves are swapped once more before the final permutation.
          plain_d = fp_perm({r_c[RPC], l_c[RPC]});
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      plain_q <= plain_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.plain_out = plain_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: four instances (1,2,4,8 rounds/cycle) behind one shared driver,
// expected plaintexts queued at each handshake and compared when the selected core delivers.
module tb_des_decrypt_core;
  import des_decrypt_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [63:0] cipher, key;
  logic [1:0]  sel;

  logic [3:0]  rdy_v, ov_v, busy_v;
  logic [63:0] po_v [4];
  logic        in_ready_m, ov_m, busy_m;
  logic [63:0] po_m;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_acc, t_first;
  logic [63:0] sb [$];

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_decrypt_core_if bus [4] ();

  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign bus[k].in_valid  = in_valid && (sel == 2'(k));
    assign bus[k].cipher_in = cipher;
    assign bus[k].key       = key;
    assign bus[k].out_ready = out_ready && (sel == 2'(k));
    assign rdy_v[k]         = bus[k].in_ready;
    assign ov_v[k]          = bus[k].out_valid;
    assign busy_v[k]        = bus[k].busy;
    assign po_v[k]          = bus[k].plain_out;

    des_decrypt_core #(.ROUNDS_PER_CYCLE(1 << k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[k])
    );
  end

  assign in_ready_m = rdy_v[sel];
  assign ov_m       = ov_v[sel];
  assign busy_m     = busy_v[sel];
  assign po_m       = po_v[sel];

  // Forward DES, written in the encrypt direction with left rotations and K1..K16.
  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t, s;
    logic [47:0] x;
    int          sh;
    cd = pc1_perm(k);
    c = cd[55:28];
    d = cd[27:0];
    {l, r} = ip_perm(pt);
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c = (c << sh) | (c >> (28 - sh));
      d = (d << sh) | (d >> (28 - sh));
      x = e_expand(r) ^ pc2_perm({c, d});
      for (int b = 0; b < 8; b++) s[31 - 4*b -: 4] = sbox(3'(b), x[47 - 6*b -: 6]);
      t = r;
      r = l ^ p_perm(s);
      l = t;
    end
    return fp_perm({r, l});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and hold it until the selected core takes it.
  task automatic send(input logic [63:0] c, input logic [63:0] k, input logic [63:0] exp,
                      input bit track);
    int n = 0;
    in_valid = 1'b1;
    cipher   = c;
    key      = k;
    @(negedge clk);
    while (!in_ready_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(in_ready_m), 64'd1);
    if (track) sb.push_back(exp);
    t_acc = cyc;
    tick();
  endtask

  task automatic wait_out(input int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov_m && n < 100);
    chk("out_valid_rise", 64'(ov_m), 64'd1);
    chk("latency", 64'(cyc - t_acc), 64'(lat));
  endtask

  // Scoreboard: every delivered block must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ov_m && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out observed=%h expected=none", po_m);
      end
      if (sb.size() > 0) chk("plain_out", po_m, sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pt, kr;
    int          lat, n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cipher    = '0;
    key       = '0;
    sel       = 2'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(rdy_v), 64'hF);
    chk("rst_out_valid", 64'(ov_v), 64'h0);
    chk("rst_busy", 64'(busy_v), 64'h0);
    chk("rst_plain_out", po_m, 64'h0);
    tick();

    // Known vectors.
    send(C1, K1, P1, 1);
    in_valid = 1'b0;
    chk("busy_in_round", 64'(busy_m), 64'd1);
    wait_out(17);
    tick();
    send(C2, K2, P2, 1);
    in_valid = 1'b0;
    wait_out(17);
    tick();

    // Backpressure with ignored input pulses.
    out_ready = 1'b0;
    send(C2, K2, P2, 1);
    in_valid = 1'b0;
    wait_out(17);
    for (int i = 0; i < 20; i++) begin
      tick();
      in_valid = i[0];
      cipher   = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_out_valid", 64'(ov_m), 64'd1);
      chk("bp_plain_out", po_m, P2);
      chk("bp_in_ready", 64'(in_ready_m), 64'd0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("post_accept_in_ready", 64'(in_ready_m), 64'd1);
    chk("post_accept_out_valid", 64'(ov_m), 64'd0);
    repeat (20) tick();
    @(negedge clk);
    chk("no_ghost_block", 64'(ov_m), 64'd0);
    tick();

    // Reset around round 8 discards the block in flight.
    send(C1, K1, P1, 0);
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready_m), 64'd1);
    chk("midrst_busy", 64'(busy_m), 64'd0);
    chk("midrst_plain_out", po_m, 64'h0);
    repeat (20) tick();
    @(negedge clk);
    chk("midrst_no_out", 64'(ov_m), 64'd0);
    tick();
    send(C1, K1, P1, 1);
    in_valid = 1'b0;
    wait_out(17);
    tick();

    // Parity bits of the key are ignored.
    send(C1, K1 ^ 64'h0101010101010101, P1, 1);
    in_valid = 1'b0;
    wait_out(17);
    tick();

    // Back-to-back random blocks on every rounds-per-cycle variant.
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      lat = 1 + 16 / (1 << s);
      tick();
      for (int i = 0; i < 100; i++) begin
        pt = {$urandom, $urandom};
        kr = {$urandom, $urandom};
        send(enc(pt, kr), kr, pt, 1);
        if (i == 0) t_first = t_acc;
      end
      in_valid = 1'b0;
      chk("b2b_throughput", 64'(t_acc - t_first), 64'(99 * (lat + 1)));
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_drained", 64'(sb.size()), 64'd0);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
